shiftreg_pingpong_buf: RTL

Parametrised successor to the single-bank 8-bit-per-cycle input shift buffer feeding the turbo interleaver.
- Accepts DW-bit beats under a valid/ready handshake and assembles them into a block of selectable length (LEN_SMALL or LEN_LARGE bits).
- Uses two ping-pong banks, so the next block can fill while the interleaver reads the previous one.
- Presents each completed block right-justified and zero-padded on a wide parallel output, held until acknowledged.

---
 rtl/shiftreg_pingpong_buf_pkg.sv | 18 +
 rtl/shiftreg_pingpong_buf_bank.sv | 63 ++++++
 rtl/shiftreg_pingpong_buf.sv | 102 ++++++++++
 3 files changed

// File: rtl/shiftreg_pingpong_buf_pkg.sv
// Shared types and constants for the ping-pong input shift buffer.
package shiftreg_pingpong_buf_pkg;

  localparam int unsigned LTE_K_MAX   = 6144;
  localparam int unsigned LTE_K_SMALL = 1056;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Width of a counter able to index n distinct values (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shiftreg_pingpong_buf_bank.sv
// One storage bank: MAX_BITS of data, captured length select and fill state.
module shiftreg_bank
  import shiftreg_pingpong_buf_pkg::*;
#(
  parameter int unsigned DW       = 8,
  parameter int unsigned MAX_BITS = LTE_K_MAX,
  parameter int unsigned CW       = cnt_width(MAX_BITS / DW)
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                wr_en,
  input  logic                wr_last,
  input  logic [CW-1:0]       wr_idx,
  input  logic [DW-1:0]       wr_data,
  input  logic                len_in,
  input  logic                clr,
  output logic [MAX_BITS-1:0] data,
  output logic                len_sel,
  output logic                full,
  output logic                filling
);

  localparam int unsigned AW = cnt_width(MAX_BITS);

  logic [MAX_BITS-1:0] data_q, data_d;
  logic                len_q, len_d;
  bank_state_e         state_q, state_d;
  logic [AW-1:0]       bit_base;

  always_comb begin
    data_d   = data_q;
    len_d    = len_q;
    state_d  = state_q;
    bit_base = AW'(wr_idx) * AW'(DW);
    if (clr) begin
      data_d  = '0;
      state_d = BANK_EMPTY;
    end else if (wr_en) begin
      data_d[bit_base +: DW] = wr_data;
      // Length is latched only by the first beat of a block.
      if (state_q == BANK_EMPTY) len_d = len_in;
      state_d = wr_last ? BANK_FULL : BANK_FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      data_q  <= '0;
      len_q   <= 1'b0;
      state_q <= BANK_EMPTY;
    end else begin
      data_q  <= data_d;
      len_q   <= len_d;
      state_q <= state_d;
    end
  end

  assign data    = data_q;
  assign len_sel = len_q;
  assign full    = (state_q == BANK_FULL);
  assign filling = (state_q == BANK_FILLING);

endmodule

// File: rtl/shiftreg_pingpong_buf.sv
// Two-bank ping-pong shift buffer assembling DW-bit beats into fixed-length blocks.
module shiftreg_pingpong_buf
  import shiftreg_pingpong_buf_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BITS  = LTE_K_MAX,
  parameter int unsigned LEN_SMALL = LTE_K_SMALL,
  parameter int unsigned LEN_LARGE = LTE_K_MAX
) (
  input  logic                clk,
  input  logic                aclr,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  input  logic                blk_len_sel,
  input  logic                flush,
  output logic                out_valid,
  output logic [MAX_BITS-1:0] out_data,
  output logic                out_len_sel,
  input  logic                out_ack,
  output logic                ovf
);

  localparam int unsigned CW     = cnt_width(MAX_BITS / DW);
  localparam int unsigned LAST_S = LEN_SMALL / DW - 1;
  localparam int unsigned LAST_L = LEN_LARGE / DW - 1;

  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [MAX_BITS-1:0] bank_data    [2];
  logic                bank_len     [2];
  logic                bank_full    [2];
  logic                bank_filling [2];
  logic                bank_wr      [2];
  logic                bank_clr     [2];

  logic accept, ack, flush_do, cur_len, last;

  assign in_ready    = ~bank_full[wr_bank_q];
  assign out_valid   = bank_full[rd_bank_q];
  assign out_data    = bank_data[rd_bank_q];
  assign out_len_sel = bank_len[rd_bank_q];
  assign ovf         = ovf_q;

  always_comb begin
    flush_do  = flush & bank_filling[wr_bank_q];
    // A beat coinciding with flush is discarded whatever the bank state.
    accept    = in_valid & in_ready & ~flush;
    ack       = out_ack & out_valid;
    cur_len   = (cnt_q == '0) ? blk_len_sel : bank_len[wr_bank_q];
    last      = accept & (cnt_q == (cur_len ? CW'(LAST_L) : CW'(LAST_S)));
    wr_bank_d = wr_bank_q ^ last;
    rd_bank_d = rd_bank_q ^ ack;
    ovf_d     = ovf_q | (in_valid & ~in_ready);
    cnt_d     = cnt_q;
    if (flush_do || last) cnt_d = '0;
    else if (accept)      cnt_d = cnt_q + CW'(1);
    for (int b = 0; b < 2; b++) begin
      bank_wr[b]  = accept & (wr_bank_q == 1'(b));
      bank_clr[b] = (ack & (rd_bank_q == 1'(b))) | (flush_do & (wr_bank_q == 1'(b)));
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    shiftreg_bank #(
      .DW       (DW),
      .MAX_BITS (MAX_BITS),
      .CW       (CW)
    ) u_bank (
      .clk     (clk),
      .aclr    (aclr),
      .wr_en   (bank_wr[b]),
      .wr_last (last),
      .wr_idx  (cnt_q),
      .wr_data (in_data),
      .len_in  (cur_len),
      .clr     (bank_clr[b]),
      .data    (bank_data[b]),
      .len_sel (bank_len[b]),
      .full    (bank_full[b]),
      .filling (bank_filling[b])
    );
  end

endmodule
